// File: rtl/adc_pkg.sv
// Shared definitions for the ADC test-pattern packer: mode/state encodings,
// pattern seeds and frame-geometry helpers.
package adc_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) r++;
        return r;
    endfunction

    function automatic int unsigned frame_words(input int unsigned num_ch, input int unsigned lanes);
        return (num_ch + lanes - 1) / lanes;
    endfunction

    // Callers truncate to SAMPLE_W, which yields the mod 2^SAMPLE_W behaviour.
    function automatic logic [63:0] seed(input int unsigned k);
        return 64'd2 << (5 * k);
    endfunction

    function automatic logic [63:0] walk_seed(input int unsigned k, input int unsigned sample_w);
        return 64'd1 << (k % sample_w);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// The head word reads as zero while the FIFO is empty.
module sync_fifo_fwft
    import adc_pkg::*;
#(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic [AW:0]      level_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_wr, do_rd;

    assign do_wr = wr_en_i && (level_q != FULL_LVL);
    assign do_rd = rd_en_i && (level_q != '0);

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_wr && !do_rd)      level_q <= level_q + 1'b1;
            else if (do_rd && !do_wr) level_q <= level_q - 1'b1;
        end
    end

    assign valid_o   = (level_q != '0);
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o   = level_q;

endmodule

// File: rtl/adc_test_pattern_packer.sv
// ADC test-pattern source and packer: substitutes live samples or a generated
// pattern per channel, packs each channel set into OUT_W words and streams them.
module adc_test_pattern_packer
    import adc_pkg::*;
#(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned OUT_W      = 64,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned AW = clog2(FIFO_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable_i,
    input  logic [1:0]                 mode_i,
    input  logic                       sample_valid_i,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OUT_W-1:0]           out_data_o,
    output logic                       out_last_o,
    output logic [AW:0]                fifo_level_o,
    output logic [31:0]                frame_cnt_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int unsigned LANES       = OUT_W / SAMPLE_W;
    localparam int unsigned FRAME_WORDS = frame_words(NUM_CH, LANES);
    localparam int unsigned WW          = (FRAME_WORDS > 1) ? clog2(FRAME_WORDS) : 1;
    localparam int unsigned PW          = FRAME_WORDS * OUT_W;
    localparam logic [AW:0]   ROOM_LVL  = (AW+1)'(FIFO_DEPTH - FRAME_WORDS);
    localparam logic [WW-1:0] LAST_W    = WW'(FRAME_WORDS - 1);

    mode_e mode_cur, mode_q;
    logic  reload, fire;
    logic [NUM_CH*SAMPLE_W-1:0] frame_in;

    assign mode_cur = mode_e'(mode_i);
    assign reload   = !enable_i || (mode_cur != mode_q);
    assign fire     = sample_valid_i && enable_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= MODE_PASS;
        else        mode_q <= mode_cur;
    end

    // A pending reload is folded into the current value so a strobe coinciding
    // with a mode change emits the new mode's seed and steps from there.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [SAMPLE_W-1:0] SEED_V = SAMPLE_W'(seed(k));
        localparam logic [SAMPLE_W-1:0] WALK_V = SAMPLE_W'(walk_seed(k, SAMPLE_W));

        logic [SAMPLE_W-1:0] gen_q, gen_d, cur_v;

        always_comb begin
            cur_v = reload ? ((mode_cur == MODE_WALK) ? WALK_V : SEED_V) : gen_q;
            gen_d = cur_v;
            if (fire) begin
                case (mode_cur)
                    MODE_RAMP: gen_d = cur_v + 1'b1;
                    MODE_WALK: gen_d = {cur_v[SAMPLE_W-2:0], cur_v[SAMPLE_W-1]};
                    default:   gen_d = cur_v;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) gen_q <= SEED_V;
            else        gen_q <= gen_d;
        end

        assign frame_in[k*SAMPLE_W +: SAMPLE_W] =
            (mode_cur == MODE_PASS) ? sample_data_i[k*SAMPLE_W +: SAMPLE_W] : cur_v;
    end

    state_e            state_q, state_d;
    logic [WW-1:0]     widx_q, widx_d;
    logic [PW-1:0]     frame_q, frame_d, frame_pad;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              wr_en, drop;
    logic [AW:0]       level;
    logic [OUT_W:0]    wr_word, head_word;

    always_comb begin
        frame_pad = '0;
        frame_pad[NUM_CH*SAMPLE_W-1:0] = frame_in;
    end

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        frame_d     = frame_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        wr_en       = 1'b0;
        drop        = 1'b0;
        if (state_q == ST_IDLE) begin
            if (fire) begin
                if (level <= ROOM_LVL) begin
                    frame_d = frame_pad;
                    widx_d  = '0;
                    state_d = ST_EMIT;
                end else begin
                    drop = 1'b1;
                end
            end
        end else begin
            wr_en = 1'b1;
            drop  = fire;
            if (widx_q == LAST_W) begin
                state_d     = ST_IDLE;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end else begin
                widx_d = widx_q + 1'b1;
            end
        end
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            widx_q      <= '0;
            frame_q     <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            frame_q     <= frame_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign wr_word = {widx_q == LAST_W, frame_q[widx_q*OUT_W +: OUT_W]};

    sync_fifo_fwft #(
        .WIDTH (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_word),
        .rd_en_i   (out_ready_i),
        .rd_data_o (head_word),
        .valid_o   (out_valid_o),
        .level_o   (level)
    );

    assign out_data_o   = head_word[OUT_W-1:0];
    assign out_last_o   = head_word[OUT_W];
    assign fifo_level_o = level;
    assign frame_cnt_o  = frame_cnt_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_adc_test_pattern_packer.sv
// Bench for adc_test_pattern_packer: a 3-channel and a 6-channel instance driven
// with directed and random strobes, checked against a queue-based frame model.
module tb_adc_test_pattern_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en [2];
    logic        sv [2];
    logic        rdy [2];
    logic [1:0]  md [2];
    logic [47:0] sd3;
    logic [95:0] sd6;
    logic        ov [2];
    logic        ol [2];
    logic [63:0] od [2];
    logic [4:0]  lvl [2];
    logic [31:0] fc [2];
    logic [15:0] dc [2];

    always #5 clk = ~clk;

    adc_test_pattern_packer dut3 (
        .clk(clk), .rst_n(rst_n), .enable_i(en[0]), .mode_i(md[0]),
        .sample_valid_i(sv[0]), .sample_data_i(sd3), .out_valid_o(ov[0]),
        .out_ready_i(rdy[0]), .out_data_o(od[0]), .out_last_o(ol[0]),
        .fifo_level_o(lvl[0]), .frame_cnt_o(fc[0]), .drop_cnt_o(dc[0])
    );

    adc_test_pattern_packer #(.NUM_CH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .enable_i(en[1]), .mode_i(md[1]),
        .sample_valid_i(sv[1]), .sample_data_i(sd6), .out_valid_o(ov[1]),
        .out_ready_i(rdy[1]), .out_data_o(od[1]), .out_last_o(ol[1]),
        .fifo_level_o(lvl[1]), .frame_cnt_o(fc[1]), .drop_cnt_o(dc[1])
    );

    typedef struct {
        logic [64:0] w;
        int          vis;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int cyc;
    int nch [2] = '{3, 6};
    int fw  [2] = '{1, 2};
    int n [2];
    int acc [2];
    int drops [2];
    int last_acc [2];
    logic [1:0] mm [2];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nvis(input int d);
        int c = 0;
        if (d == 0) begin
            foreach (q0[i]) if (q0[i].vis <= cyc) c++;
        end else begin
            foreach (q1[i]) if (q1[i].vis <= cyc) c++;
        end
        return c;
    endfunction

    // Pattern value for channel k of the frame emitted by the next strobe.
    function automatic logic [15:0] gval(input int d, input int k);
        longint s = (longint'(2) << (5 * k)) % 65536;
        case (mm[d])
            2'd0:    return (d == 0) ? sd3[k*16 +: 16] : sd6[k*16 +: 16];
            2'd1:    return 16'((s + n[d]) % 65536);
            2'd2:    return 16'(s);
            default: return 16'(longint'(1) << (((k % 16) + n[d]) % 16));
        endcase
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            n[d] = 0; acc[d] = 0; drops[d] = 0; last_acc[d] = -100;
        end
    endtask

    task automatic step();
        ent_t e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int v = nvis(d);
            chk($sformatf("level%0d", d), 96'(lvl[d]), 96'(v));
            chk($sformatf("valid%0d", d), 96'(ov[d]), 96'(v > 0));
            if (ov[d] && rdy[d] && v > 0) begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("word%0d", d), 96'({ol[d], od[d]}), 96'(e.w));
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_mode(input int d, input logic [1:0] m);
        if (m != mm[d]) n[d] = 0;
        mm[d] = m;
        md[d] = m;
    endtask

    task automatic set_en(input int d, input logic v);
        if (!v) n[d] = 0;
        en[d] = v;
    endtask

    task automatic strobe(input int d, input int gap);
        ent_t e;
        sv[d] = 1'b1;
        if (en[d]) begin
            if ((cyc > last_acc[d] + fw[d]) && (nvis(d) <= 16 - fw[d])) begin
                for (int w = 0; w < fw[d]; w++) begin
                    e.w = '0;
                    for (int j = 0; j < 4; j++)
                        if (w * 4 + j < nch[d]) e.w[j*16 +: 16] = gval(d, w * 4 + j);
                    e.w[64] = (w == fw[d] - 1);
                    e.vis = cyc + 2 + w;
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
                acc[d]++;
                last_acc[d] = cyc;
            end else if (drops[d] < 65535) begin
                drops[d]++;
            end
            n[d]++;
        end
        step();
        sv[d] = 1'b0;
        for (int i = 1; i < gap; i++) step();
    endtask

    task automatic chk_counters(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_frames%0d", tag, d), 96'(fc[d]), 96'(acc[d]));
            chk($sformatf("%s_drops%0d", tag, d), 96'(dc[d]), 96'(drops[d]));
        end
    endtask

    initial begin
        int f0, d0;
        rst_n = 1'b0;
        cyc = 0;
        sd3 = '0;
        sd6 = '0;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; sv[d] = 1'b0; rdy[d] = 1'b1; md[d] = 2'd0; mm[d] = 2'd0;
        end
        model_reset();
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", 96'(ov[d]), 96'(0));
            chk("rst_data", 96'({ol[d], od[d]}), 96'(0));
            chk("rst_cnt", 96'({fc[d], dc[d]}), 96'(0));
        end
        rst_n = 1'b1;
        step();

        // Ramp, 4 strobes spaced 3 clk; first word carries the seeds at t+2.
        set_mode(0, 2'd1);
        set_en(0, 1'b1);
        strobe(0, 1);
        chk("lat_t1_valid", 96'(ov[0]), 96'(0));
        step();
        chk("lat_t2_word", 96'({ol[0], od[0]}), 96'({1'b1, 64'h0000_0800_0040_0002}));
        step();
        repeat (3) strobe(0, 3);
        repeat (3) step();
        chk_counters("ramp");

        // Pass-through with a fixed and several random channel sets.
        set_mode(0, 2'd0);
        step();
        sd3 = {16'hAAAA, 16'h5555, 16'h1234};
        strobe(0, 2);
        chk("pass_word", 96'({ol[0], od[0]}), 96'({1'b1, 64'h0000_AAAA_5555_1234}));
        step();
        for (int i = 0; i < 5; i++) begin
            sd3 = {$urandom, $urandom};
            strobe(0, 3);
        end

        // Six channels: two words per frame, strobe during EMIT is dropped.
        set_mode(1, 2'd1);
        set_en(1, 1'b1);
        step();
        strobe(1, 1);
        strobe(1, 5);
        chk("emit_drop", 96'(dc[1]), 96'(1));
        chk_counters("six");

        // Backpressure: FIFO fills, later frames dropped, ramp gap visible on drain.
        f0 = acc[0];
        d0 = drops[0];
        rdy[0] = 1'b0;
        set_mode(0, 2'd1);
        repeat (20) strobe(0, 3);
        chk("bp_level", 96'(lvl[0]), 96'(16));
        chk("bp_frames", 96'(fc[0]), 96'(f0 + 16));
        chk("bp_drops", 96'(dc[0]), 96'(d0 + 4));
        rdy[0] = 1'b1;
        repeat (20) step();
        chk_counters("bp");

        // Walking one wraps after SAMPLE_W strobes; a mode change restarts at seeds.
        set_mode(0, 2'd3);
        repeat (17) strobe(0, 2);
        set_mode(0, 2'd2);
        repeat (2) strobe(0, 2);
        set_mode(0, 2'd1);
        repeat (3) strobe(0, 2);
        step();
        chk_counters("walk");

        // Random modes, enables, data, backpressure and spacing on both instances.
        for (int i = 0; i < 60; i++) begin
            int d = i % 2;
            if ($urandom_range(0, 3) == 0) set_mode(d, 2'($urandom_range(0, 3)));
            set_en(d, $urandom_range(0, 5) != 0);
            rdy[d] = $urandom_range(0, 2) != 0;
            sd3 = {$urandom, $urandom};
            sd6 = {$urandom, $urandom, $urandom};
            strobe(d, fw[d] + 1 + int'($urandom_range(0, 2)));
        end
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        set_en(0, 1'b1);
        set_en(1, 1'b1);
        repeat (40) step();
        chk_counters("rand");

        // Reset asserted mid-EMIT with five words queued in the 6-channel instance.
        rdy[1] = 1'b0;
        set_mode(1, 2'd1);
        step();
        strobe(1, 3);
        strobe(1, 3);
        strobe(1, 2);
        chk("pre_rst_level", 96'(lvl[1]), 96'(5));
        rst_n = 1'b0;
        #1;
        chk("async_valid", 96'(ov[1]), 96'(0));
        chk("async_data", 96'({ol[1], od[1]}), 96'(0));
        chk("async_level", 96'(lvl[1]), 96'(0));
        chk("async_cnt", 96'({fc[1], dc[1]}), 96'(0));
        model_reset();
        step();
        rst_n = 1'b1;
        rdy[1] = 1'b1;
        step();
        strobe(1, 2);
        chk("post_rst_w0", 96'({ol[1], od[1]}), 96'({1'b0, 64'h0000_0800_0040_0002}));
        step();
        step();
        chk("post_rst_frames", 96'(fc[1]), 96'(1));
        chk_counters("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
